// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and EX operand
// forwarding, driven from a scoreboard of the instructions in EX, MEM, WB and RET.
module hazard_controller #(
    parameter int REG_NUM_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_idValid,
    input  logic [REG_NUM_WIDTH-1:0] i_idRs,
    input  logic [REG_NUM_WIDTH-1:0] i_idRt,
    input  logic                     i_idUsesRs,
    input  logic                     i_idUsesRt,
    input  logic                     i_idWrEnable,
    input  logic [REG_NUM_WIDTH-1:0] i_idWrNum,
    input  logic                     i_idIsLoad,
    input  logic                     i_idIsBranch,
    input  logic                     i_memBrTaken,
    input  logic [DATA_WIDTH-1:0]    i_wbWrData,
    output logic                     o_ifStall,
    output logic                     o_idBubble,
    output logic                     o_flushIF,
    output logic                     o_flushID,
    output logic                     o_flushEX,
    output logic [1:0]               o_fwdSelA,
    output logic [1:0]               o_fwdSelB,
    output logic [DATA_WIDTH-1:0]    o_retData,
    output logic [CNT_WIDTH-1:0]     o_stallCount,
    output logic [CNT_WIDTH-1:0]     o_flushCount
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;
    localparam logic [1:0] FWD_RET = 2'd3;

    logic                     r_exValid;
    logic                     r_exWrEn;
    logic [REG_NUM_WIDTH-1:0] r_exWrNum;
    logic                     r_exIsLoad;
    logic                     r_exIsBranch;
    logic [REG_NUM_WIDTH-1:0] r_exRs;
    logic [REG_NUM_WIDTH-1:0] r_exRt;
    logic                     r_exUsesRs;
    logic                     r_exUsesRt;

    logic                     r_memValid;
    logic                     r_memWrEn;
    logic [REG_NUM_WIDTH-1:0] r_memWrNum;
    logic                     r_memIsLoad;
    logic                     r_memIsBranch;

    logic                     r_wbValid;
    logic                     r_wbWrEn;
    logic [REG_NUM_WIDTH-1:0] r_wbWrNum;

    logic                     r_retValid;
    logic [REG_NUM_WIDTH-1:0] r_retWrNum;
    logic [DATA_WIDTH-1:0]    r_retData;

    logic [CNT_WIDTH-1:0]     r_stallCount;
    logic [CNT_WIDTH-1:0]     r_flushCount;

    logic w_branch;
    logic w_loadUse;
    logic w_issue;

    // Register 0 is hard-wired, so it never counts as produced.
    function automatic logic producerOf(input logic v, input logic we,
                                        input logic [REG_NUM_WIDTH-1:0] wn,
                                        input logic [REG_NUM_WIDTH-1:0] r);
        return v && we && (wn == r) && (r != '0);
    endfunction

    function automatic logic loadProducerOf(input logic [REG_NUM_WIDTH-1:0] r);
        return (producerOf(r_exValid, r_exWrEn, r_exWrNum, r) && r_exIsLoad) ||
               (producerOf(r_memValid, r_memWrEn, r_memWrNum, r) && r_memIsLoad);
    endfunction

    // Youngest producer wins; a load in MEM has no data yet and is skipped.
    function automatic logic [1:0] fwdPick(input logic [REG_NUM_WIDTH-1:0] r,
                                           input logic uses);
        if (!(r_exValid && uses))
            return FWD_RF;
        else if (producerOf(r_memValid, r_memWrEn, r_memWrNum, r) && !r_memIsLoad)
            return FWD_MEM;
        else if (producerOf(r_wbValid, r_wbWrEn, r_wbWrNum, r))
            return FWD_WB;
        else if (producerOf(r_retValid, 1'b1, r_retWrNum, r))
            return FWD_RET;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        w_branch  = i_memBrTaken && r_memValid && r_memIsBranch;
        w_loadUse = i_idValid &&
                    ((i_idUsesRs && loadProducerOf(i_idRs)) ||
                     (i_idUsesRt && loadProducerOf(i_idRt)));
        o_ifStall  = w_loadUse && !w_branch;
        o_idBubble = w_loadUse && !w_branch;
        o_flushIF  = w_branch;
        o_flushID  = w_branch;
        o_flushEX  = w_branch;
        o_fwdSelA  = fwdPick(r_exRs, r_exUsesRs);
        o_fwdSelB  = fwdPick(r_exRt, r_exUsesRt);
        w_issue    = i_idValid && !o_idBubble && !w_branch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exValid     <= 1'b0;
            r_exWrEn      <= 1'b0;
            r_exWrNum     <= '0;
            r_exIsLoad    <= 1'b0;
            r_exIsBranch  <= 1'b0;
            r_exRs        <= '0;
            r_exRt        <= '0;
            r_exUsesRs    <= 1'b0;
            r_exUsesRt    <= 1'b0;
            r_memValid    <= 1'b0;
            r_memWrEn     <= 1'b0;
            r_memWrNum    <= '0;
            r_memIsLoad   <= 1'b0;
            r_memIsBranch <= 1'b0;
            r_wbValid     <= 1'b0;
            r_wbWrEn      <= 1'b0;
            r_wbWrNum     <= '0;
            r_retValid    <= 1'b0;
            r_retWrNum    <= '0;
            r_retData     <= '0;
        end else begin
            r_retValid    <= r_wbValid && r_wbWrEn;
            r_retWrNum    <= r_wbWrNum;
            r_retData     <= i_wbWrData;
            r_wbValid     <= r_memValid;
            r_wbWrEn      <= r_memWrEn;
            r_wbWrNum     <= r_memWrNum;
            r_memValid    <= r_exValid && !w_branch;
            r_memWrEn     <= r_exWrEn;
            r_memWrNum    <= r_exWrNum;
            r_memIsLoad   <= r_exIsLoad;
            r_memIsBranch <= r_exIsBranch;
            r_exValid     <= w_issue;
            r_exWrEn      <= i_idWrEnable;
            r_exWrNum     <= i_idWrNum;
            r_exIsLoad    <= i_idIsLoad;
            r_exIsBranch  <= i_idIsBranch;
            r_exRs        <= i_idRs;
            r_exRt        <= i_idRt;
            r_exUsesRs    <= i_idUsesRs;
            r_exUsesRt    <= i_idUsesRt;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (o_idBubble && (r_stallCount != '1))
                r_stallCount <= r_stallCount + CNT_WIDTH'(1);
            if (w_branch && (r_flushCount != '1))
                r_flushCount <= r_flushCount + CNT_WIDTH'(1);
        end
    end

    assign o_retData    = r_retData;
    assign o_stallCount = r_stallCount;
    assign o_flushCount = r_flushCount;

endmodule
